// File: rtl/tetris_pkg.sv
// Shared types, LFSR taps and the piece footprint used by the falling-piece controller.
// The footprint must stay in step with the downstream pixel mapper.
package tetris_pkg;

    typedef enum logic [1:0] {SH_BAR = 2'b00, SH_SQUARE = 2'b01, SH_T = 2'b10, SH_L = 2'b11} shape_t;
    typedef enum logic [1:0] {COL_RED = 2'b00, COL_GREEN = 2'b01, COL_BLUE = 2'b10, COL_YELLOW = 2'b11} color_t;
    typedef enum logic [2:0] {
        SPAWN       = 3'd0,
        FALL        = 3'd1,
        LOCK        = 3'd2,
        CLEAR_SCAN  = 3'd3,
        CLEAR_SHIFT = 3'd4,
        GAME_OVER   = 3'd5
    } state_t;

    // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Wide enough for CW+2 / RW+2 on any grid up to 32 x 32
    localparam int COORD_W = 8;
    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [4:0]   valid;
        coord_t [4:0] xs;
        coord_t [4:0] ys;
    } fp_t;

    function automatic fp_t footprint(input shape_t shape, input logic [1:0] rot,
                                      input coord_t x, input coord_t y);
        fp_t    f;
        coord_t dx;
        coord_t dy;
        f  = '0;
        dx = 8'sd0;
        dy = 8'sd0;
        case (shape)
            SH_BAR: begin
                f.valid = 5'b11111;
                for (int i = 0; i < 5; i++) begin
                    f.xs[i] = rot[0] ? x : x + coord_t'(i - 2);
                    f.ys[i] = rot[0] ? y + coord_t'(i - 2) : y;
                end
            end
            SH_SQUARE: begin
                f.valid = 5'b01111;
                f.xs[0] = x;         f.ys[0] = y;
                f.xs[1] = x + 8'sd1; f.ys[1] = y;
                f.xs[2] = x;         f.ys[2] = y + 8'sd1;
                f.xs[3] = x + 8'sd1; f.ys[3] = y + 8'sd1;
            end
            SH_T, SH_L: begin
                f.valid = 5'b01111;
                // Three-cell spine: horizontal for rot 0/2, vertical for rot 1/3
                for (int i = 0; i < 3; i++) begin
                    f.xs[i] = rot[0] ? x : x + coord_t'(i - 1);
                    f.ys[i] = rot[0] ? y + coord_t'(i - 1) : y;
                end
                case ({shape[0], rot})
                    3'b0_00: begin dx = 8'sd0;  dy = 8'sd1;  end
                    3'b0_01: begin dx = -8'sd1; dy = 8'sd0;  end
                    3'b0_10: begin dx = 8'sd0;  dy = -8'sd1; end
                    3'b0_11: begin dx = 8'sd1;  dy = 8'sd0;  end
                    3'b1_00: begin dx = 8'sd1;  dy = 8'sd1;  end
                    3'b1_01: begin dx = -8'sd1; dy = 8'sd1;  end
                    3'b1_10: begin dx = -8'sd1; dy = -8'sd1; end
                    3'b1_11: begin dx = 8'sd1;  dy = -8'sd1; end
                    default: begin dx = 8'sd0;  dy = 8'sd0;  end
                endcase
                f.xs[3] = x + dx;
                f.ys[3] = y + dy;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/piece_collide.sv
// Combinational hit test of a candidate footprint against walls, floor and stopped cells.
module piece_collide
    import tetris_pkg::*;
#(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  fp_t                        fp_i,
    input  logic [ROWS-1:0][COLS-1:0]  grid_i,
    output logic                       hit_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [4:0] cell_hit_s;

    // Per-cell hit; the grid is only indexed once the cell is known to be in range
    always_comb begin
        cell_hit_s = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (!fp_i.valid[i]) begin
                cell_hit_s[i] = 1'b0;
            end else if (fp_i.xs[i][COORD_W-1] || fp_i.ys[i][COORD_W-1]) begin
                cell_hit_s[i] = 1'b1;
            end else if ((fp_i.xs[i] >= coord_t'(COLS)) || (fp_i.ys[i] >= coord_t'(ROWS))) begin
                cell_hit_s[i] = 1'b1;
            end else begin
                cell_hit_s[i] = grid_i[fp_i.ys[i][RW-1:0]][fp_i.xs[i][CW-1:0]];
            end
        end
        hit_o = |cell_hit_s;
    end

endmodule

// File: rtl/piece_controller.sv
// Falling-piece game logic: spawn, move/rotate/drop, lock into the stopped grid, clear full rows.
module piece_controller
    import tetris_pkg::*;
#(
    parameter int         COLS           = 10,
    parameter int         ROWS           = 20,
    parameter int         GRAVITY_FRAMES = 30,
    parameter int         SPAWN_X        = 4,
    parameter int         SPAWN_Y        = 1,
    parameter logic [7:0] LFSR_SEED      = 8'hA5,
    localparam int        CW             = $clog2(COLS),
    localparam int        RW             = $clog2(ROWS)
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              frame_tick,
    input  logic                              cmd_left,
    input  logic                              cmd_right,
    input  logic                              cmd_rot,
    input  logic                              cmd_drop,
    input  logic                              dbg_shape_en,
    input  logic [1:0]                        dbg_shape,
    output logic [CW-1:0]                     BlockX,
    output logic [RW-1:0]                     BlockY,
    output logic [1:0]                        Shape,
    output logic [1:0]                        Rotation,
    output logic [1:0]                        BlockColor,
    output logic                              piece_valid,
    output logic [ROWS-1:0][COLS-1:0]         block_grid,
    output logic [ROWS-1:0][COLS-1:0][1:0]    color_grid,
    output logic                              block_stop,
    output logic [15:0]                       lines_cleared,
    output logic                              game_over
);

    localparam int GW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;

    state_t                        state_q;
    logic [7:0]                    lfsr_q;
    logic [CW-1:0]                 block_x_q;
    logic [RW-1:0]                 block_y_q;
    shape_t                        shape_q;
    logic [1:0]                    rot_q;
    color_t                        color_q;
    logic                          valid_q;
    logic                          stop_q;
    logic [ROWS-1:0][COLS-1:0]     grid_q;
    logic [ROWS-1:0][COLS-1:0][1:0] cgrid_q;
    logic [15:0]                   lines_q;
    logic                          over_q;
    logic [GW-1:0]                 grav_q;
    logic [RW-1:0]                 row_q;
    logic [RW-1:0]                 shift_q;

    logic   grav_fire_s;
    logic   down_s;
    logic   move_s;
    shape_t cand_shape_s;
    logic [1:0] cand_rot_s;
    coord_t cand_x_s;
    coord_t cand_y_s;
    fp_t    cand_fp_s;
    fp_t    cur_fp_s;
    logic   hit_s;

    // Candidate pose: the spawn pose in SPAWN, otherwise the single highest-priority FALL action
    always_comb begin
        grav_fire_s  = frame_tick && (grav_q == GW'(GRAVITY_FRAMES - 1));
        down_s       = grav_fire_s || cmd_drop;
        move_s       = 1'b0;
        cand_shape_s = shape_q;
        cand_rot_s   = rot_q;
        cand_x_s     = coord_t'(block_x_q);
        cand_y_s     = coord_t'(block_y_q);
        if (state_q == SPAWN) begin
            cand_shape_s = dbg_shape_en ? shape_t'(dbg_shape) : shape_t'(lfsr_q[1:0]);
            cand_rot_s   = 2'b00;
            cand_x_s     = coord_t'(SPAWN_X);
            cand_y_s     = coord_t'(SPAWN_Y);
        end else if (down_s) begin
            cand_y_s = coord_t'(block_y_q) + 8'sd1;
        end else if (cmd_rot) begin
            move_s     = 1'b1;
            cand_rot_s = (shape_q == SH_SQUARE) ? 2'b00 : rot_q + 2'b01;
        end else if (cmd_left) begin
            move_s   = 1'b1;
            cand_x_s = coord_t'(block_x_q) - 8'sd1;
        end else if (cmd_right) begin
            move_s   = 1'b1;
            cand_x_s = coord_t'(block_x_q) + 8'sd1;
        end else begin
            move_s = 1'b0;
        end
        cand_fp_s = footprint(cand_shape_s, cand_rot_s, cand_x_s, cand_y_s);
        cur_fp_s  = footprint(shape_q, rot_q, coord_t'(block_x_q), coord_t'(block_y_q));
    end

    piece_collide #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_collide (
        .fp_i   (cand_fp_s),
        .grid_i (grid_q),
        .hit_o  (hit_s)
    );

    // Game FSM with all state and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= SPAWN;
            lfsr_q    <= LFSR_SEED;
            block_x_q <= CW'(SPAWN_X);
            block_y_q <= RW'(SPAWN_Y);
            shape_q   <= SH_BAR;
            rot_q     <= 2'b00;
            color_q   <= COL_RED;
            valid_q   <= 1'b0;
            stop_q    <= 1'b0;
            grid_q    <= '0;
            cgrid_q   <= '0;
            lines_q   <= 16'd0;
            over_q    <= 1'b0;
            grav_q    <= '0;
            row_q     <= '0;
            shift_q   <= '0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            stop_q <= 1'b0;
            case (state_q)
                SPAWN: begin
                    shape_q   <= cand_shape_s;
                    color_q   <= color_t'(lfsr_q[3:2]);
                    block_x_q <= CW'(SPAWN_X);
                    block_y_q <= RW'(SPAWN_Y);
                    rot_q     <= 2'b00;
                    grav_q    <= '0;
                    if (hit_s) begin
                        state_q <= GAME_OVER;
                        over_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        state_q <= FALL;
                        valid_q <= 1'b1;
                    end
                end
                FALL: begin
                    if (down_s) begin
                        grav_q <= '0;
                        if (hit_s) begin
                            state_q <= LOCK;
                        end else begin
                            block_y_q <= cand_y_s[RW-1:0];
                        end
                    end else begin
                        if (frame_tick) begin
                            grav_q <= grav_q + GW'(1);
                        end
                        if (move_s && !hit_s) begin
                            block_x_q <= cand_x_s[CW-1:0];
                            rot_q     <= cand_rot_s;
                        end
                    end
                end
                LOCK: begin
                    for (int i = 0; i < 5; i++) begin
                        if (cur_fp_s.valid[i]) begin
                            grid_q[cur_fp_s.ys[i][RW-1:0]][cur_fp_s.xs[i][CW-1:0]]  <= 1'b1;
                            cgrid_q[cur_fp_s.ys[i][RW-1:0]][cur_fp_s.xs[i][CW-1:0]] <= color_q;
                        end
                    end
                    stop_q  <= 1'b1;
                    valid_q <= 1'b0;
                    row_q   <= RW'(ROWS - 1);
                    state_q <= CLEAR_SCAN;
                end
                CLEAR_SCAN: begin
                    if (&grid_q[row_q]) begin
                        if (lines_q != 16'hFFFF) begin
                            lines_q <= lines_q + 16'd1;
                        end
                        shift_q <= row_q;
                        state_q <= CLEAR_SHIFT;
                    end else if (row_q == '0) begin
                        state_q <= SPAWN;
                    end else begin
                        row_q <= row_q - RW'(1);
                    end
                end
                CLEAR_SHIFT: begin
                    // row_q is left alone so a row refilled by the shift is scanned again
                    if (shift_q == '0) begin
                        grid_q[0]  <= '0;
                        cgrid_q[0] <= '0;
                        state_q    <= CLEAR_SCAN;
                    end else begin
                        grid_q[shift_q]  <= grid_q[shift_q - RW'(1)];
                        cgrid_q[shift_q] <= cgrid_q[shift_q - RW'(1)];
                        shift_q          <= shift_q - RW'(1);
                    end
                end
                GAME_OVER: begin
                    valid_q <= 1'b0;
                    over_q  <= 1'b1;
                end
                default: state_q <= SPAWN;
            endcase
        end
    end

    assign BlockX        = block_x_q;
    assign BlockY        = block_y_q;
    assign Shape         = shape_q;
    assign Rotation      = rot_q;
    assign BlockColor    = color_q;
    assign piece_valid   = valid_q;
    assign block_grid    = grid_q;
    assign color_grid    = cgrid_q;
    assign block_stop    = stop_q;
    assign lines_cleared = lines_q;
    assign game_over     = over_q;

endmodule
